// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the program/data memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_HOST
    } owner_t;

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

endpackage

// File: rtl/mem_arb_age_counter.sv
// Saturating age counter: counts denied cycles up to MAX; clear has priority over increment.
module mem_arb_age_counter #(
    parameter int MAX = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    assign sat = (count_reg == W'(MAX));

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && !sat) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU controller and the host loader,
// with host starvation protection and a host-exclusive lock mode.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    state_t state_reg, state_next;
    owner_t owner_reg, owner_next;
    logic   wait_sat;

    mem_arb_age_counter #(
        .MAX (MAX_WAIT)
    ) u_age (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (host_req && !host_gnt),
        .clr     (host_gnt || !host_req),
        .sat     (wait_sat)
    );

    // Grant priority: starved host, then CPU, then host; lock shuts the CPU out.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (reset_n) begin
            if (state_reg == ST_LOCKED) begin
                host_gnt = host_req;
            end else if (host_req && wait_sat) begin
                host_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else begin
                host_gnt = host_req;
            end
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARB:    if (host_gnt && host_lock) state_next = ST_LOCKED;
            ST_LOCKED: if (!host_lock) state_next = ST_ARB;
            default:   state_next = ST_ARB;
        endcase
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (cpu_gnt && !cpu_we) begin
            owner_next = OWN_CPU;
        end else if (host_gnt && !host_we) begin
            owner_next = OWN_HOST;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= ST_ARB;
            owner_reg <= OWN_NONE;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    // Return data is suppressed while reset is held so an in-flight read never surfaces.
    assign cpu_rvalid  = reset_n && (owner_reg == OWN_CPU);
    assign host_rvalid = reset_n && (owner_reg == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;
    assign locked      = (state_reg == ST_LOCKED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a behavioural arbitration/memory model.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              host_req, host_we, host_lock;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt, host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              locked;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_lock   (host_lock),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .locked      (locked)
    );

    // Synchronous single-port memory attached to the arbiter.
    logic [DATA_W-1:0] mem_array [32];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem_array[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_array[mem_addr];
        end
    end

    // Reference model state.
    int                checks = 0;
    int                errors = 0;
    int                wait_m = 0;
    bit                locked_m = 1'b0;
    int                pend_m = 0;          // 0 none, 1 cpu, 2 host
    logic [DATA_W-1:0] pend_data = '0;
    logic [DATA_W-1:0] ref_mem [32];
    logic              obs_cpu_gnt, obs_host_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c_req, input logic c_we, input logic [ADDR_W-1:0] c_addr,
                         input logic [DATA_W-1:0] c_wdata, input logic h_req, input logic h_we,
                         input logic [ADDR_W-1:0] h_addr, input logic [DATA_W-1:0] h_wdata,
                         input logic h_lock);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
        host_req = h_req; host_we = h_we; host_addr = h_addr; host_wdata = h_wdata;
        host_lock = h_lock;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check the current cycle against the model, advance the model, then cross the clock edge.
    task automatic cycle();
        logic              ec, eh, ew;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic              ecv, ehv;
        #3;
        ec = 1'b0;
        eh = 1'b0;
        if (reset_n) begin
            if (locked_m)                           eh = host_req;
            else if (host_req && wait_m == MAX_WAIT) eh = 1'b1;
            else if (cpu_req)                       ec = 1'b1;
            else                                    eh = host_req;
        end
        ew = ec ? cpu_we    : (eh ? host_we    : 1'b0);
        ea = ec ? cpu_addr  : (eh ? host_addr  : '0);
        ed = ec ? cpu_wdata : (eh ? host_wdata : '0);
        ecv = reset_n && (pend_m == 1);
        ehv = reset_n && (pend_m == 2);
        chk("cpu_gnt",     32'(cpu_gnt),     32'(ec));
        chk("host_gnt",    32'(host_gnt),    32'(eh));
        chk("mem_en",      32'(mem_en),      32'(ec | eh));
        chk("mem_we",      32'(mem_we),      32'(ew));
        chk("mem_addr",    32'(mem_addr),    32'(ea));
        chk("mem_wdata",   32'(mem_wdata),   32'(ed));
        chk("cpu_rvalid",  32'(cpu_rvalid),  32'(ecv));
        chk("host_rvalid", 32'(host_rvalid), 32'(ehv));
        chk("cpu_rdata",   32'(cpu_rdata),   ecv ? 32'(pend_data) : 32'd0);
        chk("host_rdata",  32'(host_rdata),  ehv ? 32'(pend_data) : 32'd0);
        chk("locked",      32'(locked),      32'(locked_m));
        obs_cpu_gnt  = cpu_gnt;
        obs_host_gnt = host_gnt;
        if (!reset_n) begin
            wait_m   = 0;
            locked_m = 1'b0;
            pend_m   = 0;
        end else begin
            pend_m = 0;
            if (ec | eh) begin
                if (ew) begin
                    ref_mem[ea] = ed;
                end else begin
                    pend_m    = ec ? 1 : 2;
                    pend_data = ref_mem[ea];
                end
            end
            if (host_req && !eh) wait_m = (wait_m < MAX_WAIT) ? wait_m + 1 : MAX_WAIT;
            else                 wait_m = 0;
            if (!locked_m) begin
                if (eh && host_lock) locked_m = 1'b1;
            end else if (!host_lock) begin
                locked_m = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int host_idx [$];

        reset_n = 1'b0;
        idle();
        @(posedge clock);
        #1;
        cycle();
        reset_n = 1'b1;

        // Reset mid-read
        drive(1, 0, 5'd3, 0, 0, 0, 0, 0, 0);
        cycle();
        reset_n = 1'b0;
        #2;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
        cycle();
        reset_n = 1'b1;
        idle();
        #2;
        chk("post_rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("post_rst_locked", 32'(locked),     32'd0);
        cycle();

        // Load every address through the host port
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 1, 1, 5'(a), 8'($urandom), 0);
            cycle();
        end

        // CPU-only fetch stream
        for (int a = 0; a < 3; a++) begin
            drive(1, 0, 5'(a), 0, 0, 0, 0, 0, 0);
            cycle();
        end
        idle();
        cycle();

        // Contention: host granted every (MAX_WAIT+1)th cycle
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 5'(k), 0, 1, 0, 5'(k + 8), 0, 0);
            cycle();
            if (obs_host_gnt) host_idx.push_back(k);
        end
        chk("contention_host_count", 32'(host_idx.size()), 32'd2);
        if (host_idx.size() >= 2) begin
            chk("contention_first_host",  32'(host_idx[0]), 32'(MAX_WAIT));
            chk("contention_second_host", 32'(host_idx[1]), 32'(2 * MAX_WAIT + 1));
        end
        idle();
        cycle();

        // Lock burst
        drive(0, 0, 0, 0, 1, 1, 5'd0, 8'h21, 1);
        cycle();
        for (int a = 1; a < 4; a++) begin
            drive(1, 0, 5'd5, 0, 1, 1, 5'(a), 8'(8'h21 + a), 1);
            #2;
            chk("lock_locked",  32'(locked),  32'd1);
            chk("lock_cpu_gnt", 32'(cpu_gnt), 32'd0);
            cycle();
        end
        drive(1, 0, 5'd5, 0, 0, 0, 0, 0, 0);
        #2;
        chk("unlock_still_locked", 32'(locked),  32'd1);
        chk("unlock_cpu_held",     32'(cpu_gnt), 32'd0);
        cycle();
        #2;
        chk("unlock_arb",     32'(locked),  32'd0);
        chk("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cycle();
        idle();
        cycle();

        // Write then read, same address
        drive(0, 0, 0, 0, 1, 1, 5'd7, 8'hA5, 0);
        cycle();
        drive(1, 0, 5'd7, 0, 0, 0, 0, 0, 0);
        cycle();
        idle();
        #2;
        chk("wr_rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("wr_rd_rdata",  32'(cpu_rdata),  32'hA5);
        cycle();

        // Idle
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("idle_mem_en",   32'(mem_en),   32'd0);
            chk("idle_mem_addr", 32'(mem_addr), 32'd0);
            cycle();
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            reset_n = ($urandom_range(0, 63) != 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 5'($urandom),
                  8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  5'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
            cycle();
        end
        reset_n = 1'b1;
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
